// File: rtl/sha_block_sequencer.sv
// Control sequencer for one SHA-256 compression engine: block accept, W load, round stepping, add-back.
// Optional SHA_SEQ_PERF_EN macro adds blk_count / busy_cycles performance counters.
module sha_block_sequencer #(
    parameter int WORDSIZE = 32,
    parameter int ROUNDS   = 64,
    localparam int BW      = 16 * WORDSIZE,
    localparam int IW      = $clog2(ROUNDS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [BW-1:0] blk_data,
    input  logic          blk_last,
    input  logic          blk_valid,
    output logic          blk_ready,
    output logic [BW-1:0] M,
    output logic          M_valid,
    output logic          round_en,
    output logic [IW-1:0] round_idx,
    output logic          hash_init,
    output logic          hash_add,
    output logic          digest_valid,
    input  logic          digest_ready
`ifdef SHA_SEQ_PERF_EN
    ,
    output logic [31:0]   blk_count,
    output logic [31:0]   busy_cycles
`endif
);

    typedef enum logic [2:0] {IDLE, LOAD, ROUND, ADD, DONE} state_e;

    state_e        state_q, state_d;
    logic [BW-1:0] m_q, m_d;
    logic          last_q, last_d;
    logic          first_blk_q, first_blk_d;
    logic [IW-1:0] round_idx_q, round_idx_d;
    logic          m_valid_q, round_en_q, hash_init_q, hash_add_q, digest_valid_q;

    always_comb begin
        state_d     = state_q;
        m_d         = m_q;
        last_d      = last_q;
        first_blk_d = first_blk_q;
        round_idx_d = round_idx_q;
        case (state_q)
            IDLE: begin
                if (blk_valid) begin
                    m_d     = blk_data;
                    last_d  = blk_last;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                first_blk_d = 1'b0;
                state_d     = ROUND;
            end
            ROUND: begin
                if (round_idx_q == IW'(ROUNDS - 1)) begin
                    round_idx_d = '0;
                    state_d     = ADD;
                end else begin
                    round_idx_d = round_idx_q + 1'b1;
                end
            end
            ADD: begin
                state_d = last_q ? DONE : IDLE;
            end
            DONE: begin
                if (digest_ready) begin
                    first_blk_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Strobes are registered from the next-state decode so they line up with the state they mark.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            m_q            <= '0;
            last_q         <= 1'b0;
            first_blk_q    <= 1'b1;
            round_idx_q    <= '0;
            m_valid_q      <= 1'b0;
            round_en_q     <= 1'b0;
            hash_init_q    <= 1'b0;
            hash_add_q     <= 1'b0;
            digest_valid_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            m_q            <= m_d;
            last_q         <= last_d;
            first_blk_q    <= first_blk_d;
            round_idx_q    <= round_idx_d;
            m_valid_q      <= (state_d == LOAD);
            round_en_q     <= (state_d == ROUND);
            hash_init_q    <= (state_d == LOAD) && first_blk_q;
            hash_add_q     <= (state_d == ADD);
            digest_valid_q <= (state_d == DONE);
        end
    end

    assign blk_ready    = (state_q == IDLE);
    assign M            = m_q;
    assign M_valid      = m_valid_q;
    assign round_en     = round_en_q;
    assign round_idx    = round_idx_q;
    assign hash_init    = hash_init_q;
    assign hash_add     = hash_add_q;
    assign digest_valid = digest_valid_q;

`ifdef SHA_SEQ_PERF_EN
    logic [31:0] blk_count_q, busy_cycles_q;

    // blk_count wraps naturally; busy_cycles sticks at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blk_count_q   <= '0;
            busy_cycles_q <= '0;
        end else begin
            if (hash_add_q) begin
                blk_count_q <= blk_count_q + 32'd1;
            end
            if ((state_q != IDLE) && (busy_cycles_q != 32'hFFFF_FFFF)) begin
                busy_cycles_q <= busy_cycles_q + 32'd1;
            end
        end
    end

    assign blk_count   = blk_count_q;
    assign busy_cycles = busy_cycles_q;
`endif

endmodule

// File: tb/tb_sha_block_sequencer.sv
// Self-checking bench for sha_block_sequencer: table of blocks plus reset corner cases,
// with a scoreboard of accepted blocks checked against the load/round/add/digest timeline.
module tb_sha_block_sequencer;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [511:0] blk_data;
    logic         blk_last;
    logic         blk_valid;
    logic         blk_ready;
    logic [511:0] M;
    logic         M_valid;
    logic         round_en;
    logic [5:0]   round_idx;
    logic         hash_init;
    logic         hash_add;
    logic         digest_valid;
    logic         digest_ready;
`ifdef SHA_SEQ_PERF_EN
    logic [31:0]  blk_count;
    logic [31:0]  busy_cycles;
`endif

    sha_block_sequencer #(.WORDSIZE(32), .ROUNDS(64)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .blk_data     (blk_data),
        .blk_last     (blk_last),
        .blk_valid    (blk_valid),
        .blk_ready    (blk_ready),
        .M            (M),
        .M_valid      (M_valid),
        .round_en     (round_en),
        .round_idx    (round_idx),
        .hash_init    (hash_init),
        .hash_add     (hash_add),
        .digest_valid (digest_valid),
        .digest_ready (digest_ready)
`ifdef SHA_SEQ_PERF_EN
        ,
        .blk_count    (blk_count),
        .busy_cycles  (busy_cycles)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [511:0] data;
        logic         last;
        logic         holdValid;
        logic         readyHigh;
        int           gap;
        logic         expFirst;
        int           digestHold;
    } vec_t;

    typedef struct packed {
        logic [511:0] data;
        logic         last;
        logic         first;
        int           acc;
    } sb_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    sb_t  sb[$];
    logic active = 1'b0;
    logic prevDv = 1'b0;
    int   curAccept = 0;
    logic curLast = 1'b0;
    int   expIdx = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Timeline monitor: every accepted block must load at T+1, round at T+2..T+65, add at T+66.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
            active = 1'b0;
            prevDv = 1'b0;
        end else begin
            checkOutput("onehot", 512'($countones({M_valid, round_en, hash_add, digest_valid, blk_ready})), 512'd1);
            if (M_valid) begin
                checkOutput("M_valid_expected", 512'(sb.size() != 0), 512'd1);
                if (sb.size() != 0) begin
                    sb_t e;
                    e = sb.pop_front();
                    checkOutput("M_data", M, e.data);
                    checkOutput("hash_init", 512'(hash_init), 512'(e.first));
                    checkOutput("load_latency", 512'(cyc), 512'(e.acc + 1));
                    curAccept = e.acc;
                    curLast   = e.last;
                    expIdx    = 0;
                    active    = 1'b1;
                end
            end else begin
                checkOutput("hash_init_without_load", 512'(hash_init), 512'd0);
            end
            if (!active) begin
                checkOutput("strobe_when_idle", 512'({round_en, hash_add, digest_valid}), 512'd0);
            end else begin
                if (round_en) begin
                    checkOutput("round_idx", 512'(round_idx), 512'(expIdx));
                    checkOutput("round_cycle", 512'(cyc), 512'(curAccept + 2 + expIdx));
                    expIdx++;
                end
                if (hash_add) begin
                    checkOutput("hash_add_cycle", 512'(cyc), 512'(curAccept + 66));
                    checkOutput("round_count", 512'(expIdx), 512'd64);
                end
                if (cyc == curAccept + 67) begin
                    checkOutput("post_add_digest_valid", 512'(digest_valid), 512'(curLast));
                    checkOutput("post_add_blk_ready", 512'(blk_ready), 512'(!curLast));
                    if (!curLast) active = 1'b0;
                end
                if (!digest_valid && prevDv) active = 1'b0;
            end
            prevDv = digest_valid;
        end
    end

    task automatic applyStimulus(input string name, input vec_t v, inout int lastAcc);
        int n;
        @(negedge clk);
        blk_data     = v.data;
        blk_last     = v.last;
        blk_valid    = 1'b1;
        digest_ready = v.readyHigh;
        n = 0;
        while (!blk_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        checkOutput({name, "_accept"}, 512'(blk_ready), 512'd1);
        if (blk_ready) begin
            if (v.gap != 0) checkOutput({name, "_gap"}, 512'(cyc - lastAcc), 512'(v.gap));
            sb.push_back('{data: v.data, last: v.last, first: v.expFirst, acc: cyc});
            lastAcc = cyc;
        end
        if (!v.holdValid) begin
            @(posedge clk);
            #1 blk_valid = 1'b0;
        end
    endtask

    task automatic waitDigest(input string name, input int holdCycles);
        int n = 0;
        @(negedge clk);
        while (!digest_valid && n < 300) begin
            @(negedge clk);
            n++;
        end
        checkOutput({name, "_digest_seen"}, 512'(digest_valid), 512'd1);
        for (int k = 0; k < holdCycles; k++) begin
            checkOutput({name, "_digest_held"}, 512'(digest_valid), 512'd1);
            checkOutput({name, "_ready_low_in_done"}, 512'(blk_ready), 512'd0);
            @(negedge clk);
        end
        digest_ready = 1'b1;
        @(negedge clk);
        checkOutput({name, "_idle_after_digest"}, 512'(blk_ready), 512'd1);
        checkOutput({name, "_digest_dropped"}, 512'(digest_valid), 512'd0);
        digest_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [511:0] abcBlk, nist1, nist2;
        vec_t vecs[5];
        int   lastAcc = 0;
        int   bad;
        int   n;

        abcBlk = {32'h61626380, {14{32'h0}}, 32'h00000018};
        nist1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                  32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                  32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                  32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
        nist2  = {{15{32'h0}}, 32'h000001c0};

        //          data    last  hold  rdyHi gap expFirst digestHold
        vecs[0] = '{nist1,  1'b0, 1'b1, 1'b1, 0,  1'b1, 0};
        vecs[1] = '{nist2,  1'b1, 1'b0, 1'b1, 67, 1'b0, 0};
        vecs[2] = '{abcBlk, 1'b1, 1'b0, 1'b1, 0,  1'b1, 0};
        vecs[3] = '{abcBlk, 1'b1, 1'b0, 1'b0, 0,  1'b1, 10};
        vecs[4] = '{abcBlk, 1'b1, 1'b0, 1'b0, 0,  1'b1, 0};

        rst_n        = 1'b0;
        blk_data     = abcBlk;
        blk_last     = 1'b1;
        blk_valid    = 1'b1;
        digest_ready = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("reset_M", M, 512'd0);
        checkOutput("reset_strobes", 512'({M_valid, round_en, hash_init, hash_add, digest_valid}), 512'd0);
        checkOutput("reset_round_idx", 512'(round_idx), 512'd0);
        checkOutput("reset_blk_ready", 512'(blk_ready), 512'd1);
        blk_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        bad = 0;
        repeat (100) begin
            @(negedge clk);
            if (!blk_ready || M_valid) bad++;
        end
        checkOutput("idle_100_cycles", 512'(bad), 512'd0);
        checkOutput("no_transfer_in_reset", M, 512'd0);

        for (int i = 0; i < 5; i++) begin
            applyStimulus($sformatf("vec%0d", i), vecs[i], lastAcc);
            if (vecs[i].last) waitDigest($sformatf("vec%0d", i), vecs[i].digestHold);
`ifdef SHA_SEQ_PERF_EN
            if (i == 1) begin
                checkOutput("perf_blk_count", 512'(blk_count), 512'd2);
                // two blocks of LOAD+64 ROUND+ADD, plus the single DONE cycle
                checkOutput("perf_busy_cycles", 512'(busy_cycles), 512'd133);
            end
`endif
        end

        // Abort a block mid-rounds; the next block must start a fresh message.
        applyStimulus("abort_blk", vecs[2], lastAcc);
        n = 0;
        while (round_idx != 6'd30 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("abort_reached_round30", 512'(round_idx), 512'd30);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("abort_round_en", 512'(round_en), 512'd0);
        checkOutput("abort_round_idx", 512'(round_idx), 512'd0);
        checkOutput("abort_blk_ready", 512'(blk_ready), 512'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        repeat (80) begin
            @(negedge clk);
            if (hash_add || digest_valid) bad++;
        end
        checkOutput("abort_no_add_or_digest", 512'(bad), 512'd0);
        applyStimulus("after_abort", vecs[4], lastAcc);
        waitDigest("after_abort", 0);

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
